seg_window_ctrl: RTL and testbench

Pixel-path controller for the six-digit segment display. Decodes the six 74×249 digit windows from the VGA counters and holds a per-slot digit register file that firmware writes through a valid/ready port, with updates committed atomically once per frame. Emits the active slot index, window-local coordinates and current digit for the downstream glyph stage, plus a 2-cycle-aligned gated pixel stream. Sits between the VGA timing generator and the colour output mux.

---
 rtl/seg_window_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg_window_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_window_ctrl.sv
// Six-window segment display pixel controller: decodes the digit windows from the
// VGA counters, holds shadow/committed digit banks and emits a 2-cycle gated pixel stream.
module seg_window_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic [11:0] pixelIn,
  input  logic        wr_valid,
  input  logic [2:0]  wr_slot,
  input  logic [3:0]  wr_digit,
  output logic        wr_ready,
  output logic [11:0] pixelOut,
  output logic        active,
  output logic [2:0]  slot_idx,
  output logic [6:0]  slot_x,
  output logic [7:0]  slot_y,
  output logic [3:0]  cur_digit,
  output logic        frame_done
);

  localparam logic [9:0]  ROW_FIRST = 10'd101;
  localparam logic [9:0]  ROW_LAST  = 10'd349;
  localparam logic [9:0]  WIN_SPAN  = 10'd73;
  localparam logic [9:0]  COMMIT_V  = 10'd480;
  localparam logic [3:0]  BLANK     = 4'hF;
  localparam logic [23:0] ALL_BLANK = 24'hFFFFFF;

  function automatic logic [9:0] winBase(input logic [2:0] k);
    case (k)
      3'd0:    winBase = 10'd101;
      3'd1:    winBase = 10'd191;
      3'd2:    winBase = 10'd281;
      3'd3:    winBase = 10'd371;
      3'd4:    winBase = 10'd461;
      3'd5:    winBase = 10'd551;
      default: winBase = 10'd0;
    endcase
  endfunction

  function automatic logic [3:0] digitSel(input logic [23:0] bank, input logic [2:0] idx);
    case (idx)
      3'd0:    digitSel = bank[3:0];
      3'd1:    digitSel = bank[7:4];
      3'd2:    digitSel = bank[11:8];
      3'd3:    digitSel = bank[15:12];
      3'd4:    digitSel = bank[19:16];
      3'd5:    digitSel = bank[23:20];
      default: digitSel = BLANK;
    endcase
  endfunction

  logic        inRows_s;
  logic [5:0]  winHit_s;
  logic        inWin_s;
  logic [2:0]  slotIdx_s;
  logic [9:0]  base_s;
  logic [6:0]  slotX_s;
  logic [7:0]  slotY_s;
  logic        commitHit_s;
  logic        writeFire_s;
  logic [23:0] shadowNext_s;
  logic [3:0]  lookDigit_s;
  logic        digitLive_s;

  logic        s1InWin_r;
  logic [2:0]  s1Slot_r;
  logic [6:0]  s1X_r;
  logic [7:0]  s1Y_r;
  logic [11:0] s1Pix_r;
  logic [23:0] shadow_r;
  logic [23:0] committed_r;

  // Out-of-range counters (>799 / >524) never satisfy these compares.
  assign inRows_s = (vcnt >= ROW_FIRST) && (vcnt <= ROW_LAST);

  for (genvar k = 0; k < 6; k++) begin : gWinHit
    assign winHit_s[k] = inRows_s && (hcnt >= winBase(3'(k))) && (hcnt <= winBase(3'(k)) + WIN_SPAN);
  end

  // Windows are disjoint, so at most one hit bit is set.
  always_comb begin
    inWin_s   = 1'b0;
    slotIdx_s = 3'd0;
    case (winHit_s)
      6'b000001: begin inWin_s = 1'b1; slotIdx_s = 3'd0; end
      6'b000010: begin inWin_s = 1'b1; slotIdx_s = 3'd1; end
      6'b000100: begin inWin_s = 1'b1; slotIdx_s = 3'd2; end
      6'b001000: begin inWin_s = 1'b1; slotIdx_s = 3'd3; end
      6'b010000: begin inWin_s = 1'b1; slotIdx_s = 3'd4; end
      6'b100000: begin inWin_s = 1'b1; slotIdx_s = 3'd5; end
      default:   begin inWin_s = 1'b0; slotIdx_s = 3'd0; end
    endcase
  end

  // Window-local coordinates, forced to zero outside any window.
  always_comb begin
    base_s  = winBase(slotIdx_s);
    slotX_s = 7'd0;
    slotY_s = 8'd0;
    if (inWin_s) begin
      slotX_s = 7'(hcnt - base_s);
      slotY_s = 8'(vcnt - ROW_FIRST);
    end else begin
      slotX_s = 7'd0;
      slotY_s = 8'd0;
    end
  end

  // Commit falls on the first vblank line; writes stall for exactly that cycle.
  assign commitHit_s = (hcnt == 10'd0) && (vcnt == COMMIT_V);
  assign wr_ready    = ~rst & ~commitHit_s;
  assign writeFire_s = wr_valid & wr_ready;

  // Shadow bank next state; slots 6 and 7 handshake but store nothing.
  always_comb begin
    shadowNext_s = shadow_r;
    if (writeFire_s) begin
      case (wr_slot)
        3'd0:    shadowNext_s[3:0]   = wr_digit;
        3'd1:    shadowNext_s[7:4]   = wr_digit;
        3'd2:    shadowNext_s[11:8]  = wr_digit;
        3'd3:    shadowNext_s[15:12] = wr_digit;
        3'd4:    shadowNext_s[19:16] = wr_digit;
        3'd5:    shadowNext_s[23:20] = wr_digit;
        default: shadowNext_s        = shadow_r;
      endcase
    end else begin
      shadowNext_s = shadow_r;
    end
  end

  // Shadow and committed digit banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r    <= ALL_BLANK;
      committed_r <= ALL_BLANK;
    end else begin
      shadow_r <= shadowNext_s;
      if (commitHit_s) begin
        committed_r <= shadow_r;
      end else begin
        committed_r <= committed_r;
      end
    end
  end

  // Stage 1: window decode, local coordinates and pixel capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1InWin_r <= 1'b0;
      s1Slot_r  <= 3'd0;
      s1X_r     <= 7'd0;
      s1Y_r     <= 8'd0;
      s1Pix_r   <= 12'h000;
    end else begin
      s1InWin_r <= inWin_s;
      s1Slot_r  <= slotIdx_s;
      s1X_r     <= slotX_s;
      s1Y_r     <= slotY_s;
      s1Pix_r   <= pixelIn;
    end
  end

  assign lookDigit_s = digitSel(committed_r, s1Slot_r);
  assign digitLive_s = (lookDigit_s != BLANK);

  // Stage 2: committed-bank lookup, gating and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixelOut   <= 12'h000;
      active     <= 1'b0;
      slot_idx   <= 3'd0;
      slot_x     <= 7'd0;
      slot_y     <= 8'd0;
      cur_digit  <= BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commitHit_s;
      if (s1InWin_r) begin
        slot_idx  <= s1Slot_r;
        slot_x    <= s1X_r;
        slot_y    <= s1Y_r;
        cur_digit <= lookDigit_s;
        active    <= digitLive_s;
        pixelOut  <= digitLive_s ? s1Pix_r : 12'h000;
      end else begin
        slot_idx  <= 3'd0;
        slot_x    <= 7'd0;
        slot_y    <= 8'd0;
        cur_digit <= BLANK;
        active    <= 1'b0;
        pixelOut  <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_seg_window_ctrl.sv
// Directed bench for seg_window_ctrl: inputs change on the falling edge and outputs
// are sampled on the following falling edge, with hand-computed expectations.
module tb_seg_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [11:0] pixelIn;
  logic        wr_valid;
  logic [2:0]  wr_slot;
  logic [3:0]  wr_digit;
  logic        wr_ready;
  logic [11:0] pixelOut;
  logic        active;
  logic [2:0]  slot_idx;
  logic [6:0]  slot_x;
  logic [7:0]  slot_y;
  logic [3:0]  cur_digit;
  logic        frame_done;

  int nVec  = 0;
  int nMiss = 0;

  seg_window_ctrl dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .pixelIn(pixelIn),
    .wr_valid(wr_valid), .wr_slot(wr_slot), .wr_digit(wr_digit), .wr_ready(wr_ready),
    .pixelOut(pixelOut), .active(active), .slot_idx(slot_idx), .slot_x(slot_x),
    .slot_y(slot_y), .cur_digit(cur_digit), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic [11:0] p);
    hcnt    = h;
    vcnt    = v;
    pixelIn = p;
    @(negedge clk);
  endtask

  task automatic idle();
    step(10'd700, 10'd10, 12'h000);
  endtask

  task automatic writeDigit(input logic [2:0] s, input logic [3:0] d);
    wr_valid = 1'b1;
    wr_slot  = s;
    wr_digit = d;
    idle();
    wr_valid = 1'b0;
  endtask

  task automatic commitFrame(input string tag);
    step(10'd0, 10'd480, 12'h000);
    checkVal(tag, 32'(frame_done), 32'd1);
  endtask

  task automatic probeChk(input string tag, input logic [9:0] h, input logic [9:0] v,
                          input logic [11:0] p, input logic [2:0] eIdx, input logic [6:0] eX,
                          input logic [7:0] eY, input logic [3:0] eDig, input logic eAct,
                          input logic [11:0] ePix);
    step(h, v, p);
    idle();
    checkVal({tag, "_idx"}, 32'(slot_idx),  32'(eIdx));
    checkVal({tag, "_x"},   32'(slot_x),    32'(eX));
    checkVal({tag, "_y"},   32'(slot_y),    32'(eY));
    checkVal({tag, "_dig"}, 32'(cur_digit), 32'(eDig));
    checkVal({tag, "_act"}, 32'(active),    32'(eAct));
    checkVal({tag, "_pix"}, 32'(pixelOut),  32'(ePix));
  endtask

  initial begin
    int  fdCount;
    int  fdWrong;
    bit  sawActive;
    bit  sawPix;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_slot  = 3'd0;
    wr_digit = 4'd0;
    hcnt     = 10'd0;
    vcnt     = 10'd0;
    pixelIn  = 12'h000;
    @(negedge clk);
    step(10'd200, 10'd200, 12'hFFF);
    step(10'd200, 10'd200, 12'hFFF);
    checkVal("rst_ready", 32'(wr_ready),  32'd0);
    checkVal("rst_dig",   32'(cur_digit), 32'hF);
    checkVal("rst_idx",   32'(slot_idx),  32'd0);
    checkVal("rst_pix",   32'(pixelOut),  32'd0);
    rst = 1'b0;

    // Sparse free-run of one frame with all slots blank.
    fdCount = 0; fdWrong = 0; sawActive = 1'b0; sawPix = 1'b0;
    for (int v = 0; v < 525; v++) begin
      if ((v % 25 == 0) || (v == 480)) begin
        for (int h = 0; h < 800; h++) begin
          step(10'(h), 10'(v), 12'h5A5 ^ 12'(h));
          if (active) sawActive = 1'b1;
          if (pixelOut != 12'h000) sawPix = 1'b1;
          if (frame_done) begin
            fdCount++;
            if (!(h == 0 && v == 480)) fdWrong++;
          end
        end
      end
    end
    checkVal("frun_active", 32'(sawActive), 32'd0);
    checkVal("frun_pix",    32'(sawPix),    32'd0);
    checkVal("frun_fdcnt",  32'(fdCount),   32'd1);
    checkVal("frun_fdpos",  32'(fdWrong),   32'd0);

    for (int k = 0; k < 6; k++) writeDigit(3'(k), 4'(k));
    idle();
    checkVal("idle_fd", 32'(frame_done), 32'd0);
    commitFrame("commit1");
    probeChk("win0", 10'd101, 10'd101, 12'h123, 3'd0, 7'd0,  8'd0,   4'd0, 1'b1, 12'h123);
    probeChk("win5", 10'd624, 10'd349, 12'h456, 3'd5, 7'd73, 8'd248, 4'd5, 1'b1, 12'h456);
    probeChk("gap100", 10'd100, 10'd200, 12'hABC, 3'd0, 7'd0,  8'd0,  4'hF, 1'b0, 12'h000);
    probeChk("gap175", 10'd175, 10'd200, 12'hABC, 3'd0, 7'd0,  8'd0,  4'hF, 1'b0, 12'h000);
    probeChk("gap190", 10'd190, 10'd200, 12'hABC, 3'd0, 7'd0,  8'd0,  4'hF, 1'b0, 12'h000);
    probeChk("gap265", 10'd265, 10'd200, 12'hABC, 3'd0, 7'd0,  8'd0,  4'hF, 1'b0, 12'h000);
    probeChk("edg101", 10'd101, 10'd200, 12'hABC, 3'd0, 7'd0,  8'd99, 4'd0, 1'b1, 12'hABC);
    probeChk("edg174", 10'd174, 10'd200, 12'hABC, 3'd0, 7'd73, 8'd99, 4'd0, 1'b1, 12'hABC);
    probeChk("edg191", 10'd191, 10'd200, 12'hABC, 3'd1, 7'd0,  8'd99, 4'd1, 1'b1, 12'hABC);
    probeChk("edg264", 10'd264, 10'd200, 12'hABC, 3'd1, 7'd73, 8'd99, 4'd1, 1'b1, 12'hABC);
    probeChk("row100", 10'd200, 10'd100, 12'hABC, 3'd0, 7'd0,  8'd0,  4'hF, 1'b0, 12'h000);
    probeChk("row350", 10'd200, 10'd350, 12'hABC, 3'd0, 7'd0,  8'd0,  4'hF, 1'b0, 12'h000);
    probeChk("hbig",   10'd1000, 10'd200, 12'hABC, 3'd0, 7'd0, 8'd0,  4'hF, 1'b0, 12'h000);

    // Blank slot 2; slot 6 must be a harmless no-op.
    writeDigit(3'd2, 4'hF);
    writeDigit(3'd6, 4'd8);
    commitFrame("commit2");
    probeChk("blank2", 10'd300, 10'd200, 12'h777, 3'd2, 7'd19, 8'd99, 4'hF, 1'b0, 12'h000);
    probeChk("nbr1",   10'd200, 10'd200, 12'h777, 3'd1, 7'd9,  8'd99, 4'd1, 1'b1, 12'h777);
    probeChk("nbr3",   10'd380, 10'd200, 12'h777, 3'd3, 7'd9,  8'd99, 4'd3, 1'b1, 12'h777);

    // Producer holds a write across the commit cycle.
    wr_valid = 1'b1; wr_slot = 3'd1; wr_digit = 4'd7;
    hcnt = 10'd0; vcnt = 10'd480; pixelIn = 12'h000;
    #1 checkVal("hold_rdy_commit", 32'(wr_ready), 32'd0);
    @(negedge clk);
    checkVal("hold_fd", 32'(frame_done), 32'd1);
    hcnt = 10'd700; vcnt = 10'd10;
    #1 checkVal("hold_rdy_next", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    probeChk("hold_old", 10'd200, 10'd200, 12'h321, 3'd1, 7'd9, 8'd99, 4'd1, 1'b1, 12'h321);
    commitFrame("commit3");
    probeChk("hold_new", 10'd200, 10'd200, 12'h321, 3'd1, 7'd9, 8'd99, 4'd7, 1'b1, 12'h321);

    // One-cycle reset mid-window flushes the pipeline and blanks both banks.
    step(10'd300, 10'd200, 12'hABC);
    rst = 1'b1;
    #1 checkVal("mid_rst_rdy", 32'(wr_ready), 32'd0);
    @(negedge clk);
    checkVal("mid_rst_idx", 32'(slot_idx),  32'd0);
    checkVal("mid_rst_x",   32'(slot_x),    32'd0);
    checkVal("mid_rst_y",   32'(slot_y),    32'd0);
    checkVal("mid_rst_dig", 32'(cur_digit), 32'hF);
    rst = 1'b0;
    step(10'd380, 10'd200, 12'hABC);
    checkVal("resume1_idx", 32'(slot_idx), 32'd0);
    idle();
    checkVal("resume2_idx", 32'(slot_idx),  32'd3);
    checkVal("resume2_dig", 32'(cur_digit), 32'hF);
    checkVal("resume2_act", 32'(active),    32'd0);
    probeChk("post_rst1", 10'd200, 10'd200, 12'hABC, 3'd1, 7'd9, 8'd99, 4'hF, 1'b0, 12'h000);
    writeDigit(3'd3, 4'd9);
    commitFrame("commit4");
    probeChk("post_rst3", 10'd380, 10'd200, 12'hABC, 3'd3, 7'd9, 8'd99, 4'd9, 1'b1, 12'hABC);
    probeChk("post_rst1b", 10'd200, 10'd200, 12'hABC, 3'd1, 7'd9, 8'd99, 4'hF, 1'b0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
